// File: rtl/mfp_uart_rx_fifo.sv
// ============================================================================
// Module   : mfp_uart_rx_fifo
// Brief    : 16x-oversampled UART receiver (8N1, or 8E1 when
//            MFP_UART_RX_PARITY_EN is defined) feeding a first-word-fall-through
//            byte FIFO with sticky overflow/framing/parity flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mfp_uart_rx_fifo #(
    parameter int CLK_HZ  = 50000000,
    parameter int BAUD    = 115200,
    parameter int FIFO_AW = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rx,
    output logic [7:0]         byte_data,
    output logic               byte_valid,
    input  logic               byte_ready,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow,
    output logic               frame_error,
    output logic               parity_error,
    input  logic               clear_errors
);

    localparam int c_div_raw = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int c_div     = (c_div_raw < 1) ? 1 : c_div_raw;
    localparam int c_dw      = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_dw-1:0] c_div_last = c_dw'(c_div - 1);
    localparam int c_depth   = 2 ** FIFO_AW;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_stop   = 3'd4;
    localparam logic [2:0] c_st_break  = 3'd5;
`ifdef MFP_UART_RX_PARITY_EN
    localparam logic [2:0] c_st_parity = 3'd3;
`endif

    logic [1:0]        r_sync;
    logic              w_rxs;
    logic [2:0]        r_state;
    logic [c_dw-1:0]   r_div;
    logic              w_tick;
    logic [3:0]        r_t;
    logic [2:0]        r_i;
    logic [7:0]        r_shift;
    logic              r_push;
    logic [7:0]        r_push_data;
    logic [FIFO_AW:0]  r_wr;
    logic [FIFO_AW:0]  r_rd;
    logic [7:0]        r_mem [c_depth];
    logic              r_overflow;
    logic              r_frame_error;
    logic              w_pop;
    logic              w_full;
    logic              w_wr_en;
    logic              w_ovf_set;
    logic              w_frame_set;
    logic              w_bit_end;

    assign w_rxs     = r_sync[1];
    assign w_tick    = (r_div == c_div_last);
    assign w_bit_end = w_tick && (r_t == 4'd15);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    // Free-running divider, re-phased to the detected start edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if ((r_state == c_st_idle) && !w_rxs) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_dw'(1);
        end
    end

`ifdef MFP_UART_RX_PARITY_EN
    logic r_par_ok;
    logic r_parity_error;
    logic w_par_set;

    assign w_par_set = (r_state == c_st_parity) && w_bit_end && ((^r_shift) ^ w_rxs);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_par_ok       <= 1'b1;
            r_parity_error <= 1'b0;
        end else begin
            if ((r_state == c_st_parity) && w_bit_end) begin
                r_par_ok <= ~((^r_shift) ^ w_rxs);
            end
            if (w_par_set) begin
                r_parity_error <= 1'b1;
            end else if (clear_errors) begin
                r_parity_error <= 1'b0;
            end
        end
    end

    assign parity_error = r_parity_error;
`else
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_t         <= 4'd0;
            r_i         <= 3'd0;
            r_shift     <= 8'h00;
            r_push      <= 1'b0;
            r_push_data <= 8'h00;
        end else begin
            r_push <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (!w_rxs) begin
                        r_state <= c_st_start;
                        r_t     <= 4'd0;
                    end
                end
                c_st_start: begin
                    if (w_tick) begin
                        if (r_t == 4'd7) begin
                            if (w_rxs) begin
                                r_state <= c_st_idle;
                            end else begin
                                r_state <= c_st_data;
                                r_t     <= 4'd0;
                                r_i     <= 3'd0;
                            end
                        end else begin
                            r_t <= r_t + 4'd1;
                        end
                    end
                end
                c_st_data: begin
                    if (w_tick) begin
                        r_t <= r_t + 4'd1;
                    end
                    if (w_bit_end) begin
                        r_shift <= {w_rxs, r_shift[7:1]};
                        r_i     <= r_i + 3'd1;
                        if (r_i == 3'd7) begin
`ifdef MFP_UART_RX_PARITY_EN
                            r_state <= c_st_parity;
`else
                            r_state <= c_st_stop;
`endif
                        end
                    end
                end
`ifdef MFP_UART_RX_PARITY_EN
                c_st_parity: begin
                    if (w_tick) begin
                        r_t <= r_t + 4'd1;
                    end
                    if (w_bit_end) begin
                        r_state <= c_st_stop;
                    end
                end
`endif
                c_st_stop: begin
                    if (w_tick) begin
                        r_t <= r_t + 4'd1;
                    end
                    if (w_bit_end) begin
                        if (w_rxs) begin
`ifdef MFP_UART_RX_PARITY_EN
                            r_push <= r_par_ok;
`else
                            r_push <= 1'b1;
`endif
                            r_push_data <= r_shift;
                            r_state     <= c_st_idle;
                        end else begin
                            r_state <= c_st_break;
                        end
                    end
                end
                c_st_break: begin
                    if (w_rxs) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // A push into a full FIFO is still accepted when the head is popped the same cycle.
    assign fifo_count  = r_wr - r_rd;
    assign byte_valid  = (fifo_count != '0);
    assign w_full      = fifo_count[FIFO_AW];
    assign w_pop       = byte_valid && byte_ready;
    assign w_wr_en     = r_push && (!w_full || w_pop);
    assign w_ovf_set   = r_push && w_full && !w_pop;
    assign w_frame_set = (r_state == c_st_stop) && w_bit_end && !w_rxs;
    assign byte_data   = byte_valid ? r_mem[r_rd[FIFO_AW-1:0]] : 8'h00;

    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr[FIFO_AW-1:0]] <= r_push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr          <= '0;
            r_rd          <= '0;
            r_overflow    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_wr <= r_wr + (FIFO_AW + 1)'(w_wr_en);
            r_rd <= r_rd + (FIFO_AW + 1)'(w_pop);
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clear_errors) begin
                r_overflow <= 1'b0;
            end
            if (w_frame_set) begin
                r_frame_error <= 1'b1;
            end else if (clear_errors) begin
                r_frame_error <= 1'b0;
            end
        end
    end

    assign overflow    = r_overflow;
    assign frame_error = r_frame_error;

endmodule

`default_nettype wire
